// File: rtl/mult_pkg.sv
// Shared types and Booth step decoding for the sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;

  typedef enum logic [1:0] {
    NOP,
    ADD,
    SUB
  } booth_op_t;

  // Unsigned mode adds M whenever the multiplier LSB is set; signed mode
  // inspects the (LSB, previous LSB) pair as in radix-2 Booth recoding.
  function automatic booth_op_t booth_decode(input logic lsb, input logic prev,
                                             input logic mode);
    booth_op_t op;
    op = NOP;
    if (!mode) begin
      op = lsb ? ADD : NOP;
    end else begin
      case ({lsb, prev})
        2'b10:   op = SUB;
        2'b01:   op = ADD;
        default: op = NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mult_addsub.sv
// Combinational WIDTH+1-bit add/subtract of the multiplicand into the upper product half.
module mult_addsub
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] m,
  input  booth_op_t        op,
  input  logic             sign_ext,
  output logic [WIDTH:0]   result
);

  logic [WIDTH:0] hi_ext;
  logic [WIDTH:0] m_ext;

  // One extra bit keeps the unsigned carry and the signed sum exact.
  assign hi_ext = {sign_ext & hi[WIDTH-1], hi};
  assign m_ext  = {sign_ext & m[WIDTH-1], m};

  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = hi_ext;
    case (op)
      ADD:     result = hi_ext + m_ext;
      SUB:     result = hi_ext - m_ext;
      default: result = hi_ext;
    endcase
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add / radix-2 Booth multiplier, one partial-product step per clock.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product_out
);

  mult_state_t          state;
  mult_state_t          next_state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   p_reg;
  logic [WIDTH-1:0]     m_reg;
  logic                 mode_reg;
  logic                 booth_prev;
  booth_op_t            op;
  logic [WIDTH:0]       sum;

  assign op = booth_decode(p_reg[0], booth_prev, mode_reg);

  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .hi       (p_reg[2*WIDTH-1:WIDTH]),
    .m        (m_reg),
    .op       (op),
    .sign_ext (mode_reg),
    .result   (sum)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      p_reg      <= '0;
      m_reg      <= '0;
      mode_reg   <= 1'b0;
      booth_prev <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            p_reg      <= {{WIDTH{1'b0}}, multiplier_in};
            m_reg      <= multiplicand_in;
            mode_reg   <= signed_mode;
            booth_prev <= 1'b0;
            cnt        <= CNT_W'(WIDTH - 1);
          end
        end
        RUN: begin
          // sum[WIDTH] is the unsigned carry or the signed sign bit; either way
          // it becomes the new MSB as the product shifts right.
          p_reg      <= {sum, p_reg[WIDTH-1:1]};
          booth_prev <= p_reg[0];
          cnt        <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign product_out = p_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised self-checking bench for seq_multiplier at WIDTH=32 and WIDTH=8.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int vectors = 0;
  int miscompares = 0;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .Reset(rst), .start(start32), .signed_mode(sm32),
    .multiplicand_in(a32), .multiplier_in(b32),
    .busy(busy32), .done(done32), .product_out(p32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .Reset(rst), .start(start8), .signed_mode(sm8),
    .multiplicand_in(a8), .multiplier_in(b8),
    .busy(busy8), .done(done8), .product_out(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: true mathematical product of the operands, truncated to 2W bits.
  function automatic logic [63:0] ref_mult(input bit w8, input bit sm,
                                           input logic [31:0] a, input logic [31:0] b);
    longint xa, xb;
    logic [63:0] r;
    if (w8) begin
      if (sm) begin xa = longint'($signed(a[7:0])); xb = longint'($signed(b[7:0])); end
      else    begin xa = longint'({56'b0, a[7:0]}); xb = longint'({56'b0, b[7:0]}); end
    end else begin
      if (sm) begin xa = longint'($signed(a)); xb = longint'($signed(b)); end
      else    begin xa = longint'({32'b0, a}); xb = longint'({32'b0, b}); end
    end
    r = 64'(xa * xb);
    if (w8) r = {48'b0, r[15:0]};
    return r;
  endfunction

  task automatic set_in(input bit w8, input logic st, input logic sm,
                        input logic [31:0] a, input logic [31:0] b);
    if (w8) begin start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin start32 = st; sm32 = sm; a32 = a; b32 = b; end
  endtask

  function automatic logic [63:0] get_p(input bit w8);
    return w8 ? {48'b0, p8} : p32;
  endfunction

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  // One full multiply; inj > 0 pulses start with other operands on that RUN cycle.
  task automatic do_mult(input bit w8, input bit sm, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
    int w;
    int busy_n;
    int done_at;
    logic [63:0] exp;
    w       = w8 ? 8 : 32;
    busy_n  = 0;
    done_at = 0;
    exp     = ref_mult(w8, sm, a, b);
    @(posedge clk); #1;
    set_in(w8, 1'b1, sm, a, b);
    @(posedge clk); #1;
    set_in(w8, 1'b0, sm, a, b);
    for (int k = 1; k <= w + 8; k++) begin
      if (get_busy(w8)) busy_n++;
      if (get_done(w8)) begin
        done_at = k;
        break;
      end
      if (k == inj) set_in(w8, 1'b1, ~sm, $urandom, $urandom);
      else          set_in(w8, 1'b0, sm, a, b);
      @(posedge clk); #1;
    end
    check("latency", 64'(done_at), 64'(w + 1));
    check("busy_cycles", 64'(busy_n), 64'(w));
    check("product", get_p(w8), exp);
    // start during the done cycle must be ignored and the result held
    set_in(w8, 1'b1, sm, ~a, ~b);
    @(posedge clk); #1;
    set_in(w8, 1'b0, sm, a, b);
    check("after_done_busy_done", {62'b0, get_busy(w8), get_done(w8)}, 64'd0);
    check("product_hold", get_p(w8), exp);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy32", {63'b0, busy32}, 64'd0);
    check("reset_done32", {63'b0, done32}, 64'd0);
    check("reset_p32", p32, 64'd0);
    check("reset_p8", {48'b0, p8}, 64'd0);
    rst = 1'b0;

    // Directed cases
    do_mult(1'b0, 1'b0, 32'd3, 32'd5, 0);
    do_mult(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mult(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd6, 0);
    do_mult(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    do_mult(1'b1, 1'b1, 32'h80, 32'hFF, 0);
    do_mult(1'b1, 1'b0, 32'h80, 32'hFF, 0);
    do_mult(1'b1, 1'b1, 32'h7F, 32'h80, 0);
    do_mult(1'b0, 1'b0, 32'd1234, 32'd5678, 5);
    do_mult(1'b1, 1'b1, 32'h85, 32'h3C, 5);

    // Abort mid-RUN with Reset on RUN cycle 10
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (9) begin @(posedge clk); #1; end
    check("run_before_abort", {63'b0, busy32}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {63'b0, busy32}, 64'd0);
    check("abort_done", {63'b0, done32}, 64'd0);
    check("abort_product", p32, 64'd0);
    done_seen = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done32 || busy32) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    do_mult(1'b0, 1'b0, 32'd2, 32'd2, 0);

    // Reset and start together: reset wins
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
    check("reset_start_busy", {63'b0, busy32}, 64'd0);
    @(posedge clk); #1;
    check("reset_start_idle", {62'b0, busy32, done32}, 64'd0);

    // Randomised operands and modes on both widths
    for (int i = 0; i < 24; i++) begin
      do_mult(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 0);
      do_mult(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential multiplier that computes one partial-product step per clock. It supersedes the fixed 32-bit product register and external control pairing, and owns its own adder/subtractor, iteration counter and control FSM. It supports unsigned shift-add and signed (radix-2 Booth) modes. It sits beside the ALU in the datapath and talks to the controller through a start/busy/done handshake.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH): width of the iteration counter.
- `clk`  in  1: single clock; all state updates on the posedge.
- `Reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiply; sampled only in IDLE.
- `signed_mode`  in  1: 0 = unsigned, 1 = two's-complement; latched with `start`.
- `multiplicand_in`  in  WIDTH: M; latched with `start`.
- `multiplier_in`  in  WIDTH: Q; latched with `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; result is valid.
- `product_out`  out  2*WIDTH: product register P.

## Operation
- FSM states:
  - IDLE: `start` moves to RUN.
  - RUN: when the counter reaches 0, move to DONE.
  - DONE: unconditionally move to IDLE.
- Load (IDLE and `start`):
  - P ← {WIDTH'0, multiplier_in}; M_reg ← multiplicand_in; mode_reg ← signed_mode.
  - booth_prev ← 0; cnt ← WIDTH-1.
- RUN step, unsigned:
  - If P[0], {c, s} = P[2W-1:W] + M_reg as a WIDTH+1-bit add; else {c, s} = {0, P_hi}.
  - P ← {c, s, P[W-1:1]}. The carry is shifted in during the same cycle, with no separate carry register.
- RUN step, signed (Booth):
  - On (P[0], booth_prev): 10 → s = P_hi − M; 01 → s = P_hi + M; 00/11 → s = P_hi.
  - The sum is formed in WIDTH+1 bits with sign-extended operands.
  - P ← {s[W], s, P[W-1:1]}, an arithmetic shift. booth_prev ← old P[0].
- cnt decrements every RUN cycle.
- `start` while busy or in DONE is ignored: no latch and no error.
- `product_out` holds its value after DONE until the next accepted `start` reloads it.
- Arithmetic: the WIDTH+1-bit internal sum never overflows, so the full 2W-bit result is exact for all operand pairs. This includes unsigned all-ones×all-ones and signed min×min.

## Timing
- Reset values:
  - State IDLE; `busy` 0; `done` 0; `product_out` 0.
  - M_reg, cnt and booth_prev are 0.
- `start` is accepted at edge 0.
- `busy` is high on cycles 1..WIDTH.
- `done` is high on cycle WIDTH+1 only, with the final `product_out`.
- Back-to-back operation: `start` may be asserted during the `done` cycle but is ignored. The earliest next accept is the IDLE cycle after DONE, giving a throughput of one multiply per WIDTH+2 cycles.
- `Reset` has priority over everything. Asserting it mid-RUN aborts: next cycle is IDLE and all outputs are at their reset values, with no `done` pulse.
- `Reset` together with `start` in the same cycle: reset wins and `start` is dropped.
- `product_out` during RUN shows intermediate partial products; its value is not specified until `done`.

## Structure
- Package `mult_pkg`:
  - State enum `mult_state_t` {IDLE, RUN, DONE}.
  - Booth op encoding `booth_op_t` {NOP, ADD, SUB}.
  - Function `booth_decode(lsb, prev, mode)`: for unsigned mode it returns ADD/NOP from the LSB.
- Sub-module `mult_addsub`, parameter WIDTH:
  - Inputs: hi (WIDTH), m (WIDTH), op, sign_ext.
  - Output: WIDTH+1-bit result, with zero- or sign-extension chosen by `sign_ext`.
  - It is combinational and instantiated once.
- Top level: FSM, counter, P register, M_reg, booth_prev.

## Test plan
- WIDTH=32, unsigned 3×5 → `done` exactly 33 cycles after the `start` edge; P = 64'h0000_0000_0000_000F; `busy` high for 32 cycles.
- Unsigned 32'hFFFF_FFFF × 32'hFFFF_FFFF → 64'hFFFF_FFFE_0000_0001 (exercises the carry path).
- Signed cases:
  - −7 × 6 → 64'hFFFF_FFFF_FFFF_FFD6.
  - 32'h8000_0000 × 32'h8000_0000 → 64'h4000_0000_0000_0000.
- WIDTH=8 cases:
  - Signed 8'h80 × 8'hFF → 16'h0080.
  - Unsigned 8'h80 × 8'hFF → 16'h7F80.
  - `done` at cycle 9.
- `start` pulsed with new operands on RUN cycle 5 → ignored; the original result is unchanged.
- `Reset` on RUN cycle 10 → next cycle IDLE, `busy` 0, `product_out` 0, no `done`. A subsequent 2×2 gives 4 with full latency.
